// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline status from the datapath, stage controls and counters back.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned REG_NUM_BITWIDTH = 5,
    parameter int unsigned CNT_BITWIDTH     = 32
);
    logic [REG_NUM_BITWIDTH-1:0] id_rs1;
    logic [REG_NUM_BITWIDTH-1:0] id_rs2;
    logic                        ex_memRead;
    logic [REG_NUM_BITWIDTH-1:0] ex_regToWrite;
    logic                        PCSrc;
    logic                        mem_memRead;
    logic                        mem_memWrite;
    logic                        dmem_ready;
    logic                        pc_write;
    logic                        if_id_write;
    logic                        id_ex_write;
    logic                        ex_mem_write;
    logic                        if_id_flush;
    logic                        id_ex_flush;
    logic                        pc_sel_branch;
    logic                        dmem_req;
    logic                        err;
    logic [CNT_BITWIDTH-1:0]     stall_cycles;
    logic [CNT_BITWIDTH-1:0]     flush_count;

    modport master (
        output id_rs1, id_rs2, ex_memRead, ex_regToWrite, PCSrc,
               mem_memRead, mem_memWrite, dmem_ready,
        input  pc_write, if_id_write, id_ex_write, ex_mem_write,
               if_id_flush, id_ex_flush, pc_sel_branch, dmem_req, err,
               stall_cycles, flush_count
    );

    modport slave (
        input  id_rs1, id_rs2, ex_memRead, ex_regToWrite, PCSrc,
               mem_memRead, mem_memWrite, dmem_ready,
        output pc_write, if_id_write, id_ex_write, ex_mem_write,
               if_id_flush, id_ex_flush, pc_sel_branch, dmem_req, err,
               stall_cycles, flush_count
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard controller: load-use bubbles, branch flushes,
// data-memory wait freezing with timeout, and stall/flush performance counters.
module pipe_hazard_ctrl #(
    parameter int unsigned REG_NUM_BITWIDTH = 5,
    parameter int unsigned CNT_BITWIDTH     = 32,
    parameter int unsigned MEM_TIMEOUT      = 16
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  hz
);
    localparam int unsigned WAIT_W = 8;

    typedef enum logic [1:0] {ST_RUN, ST_MEM_WAIT, ST_ERR} state_t;

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic              load_use;
    logic              mem_access;
    logic              mem_stall;
    logic              advance;
    logic              branch_taken;

    always_comb begin
        load_use   = hz.ex_memRead && (hz.ex_regToWrite != '0) &&
                     ((hz.ex_regToWrite == hz.id_rs1) || (hz.ex_regToWrite == hz.id_rs2));
        mem_access = hz.mem_memRead | hz.mem_memWrite;
    end

    // Next state, wait counter and all combinational stage controls
    always_comb begin
        state_nxt        = state;
        wait_cnt_nxt     = wait_cnt;
        hz.dmem_req      = 1'b0;
        hz.pc_write      = 1'b0;
        hz.if_id_write   = 1'b0;
        hz.id_ex_write   = 1'b0;
        hz.ex_mem_write  = 1'b0;
        hz.if_id_flush   = 1'b0;
        hz.id_ex_flush   = 1'b0;
        hz.pc_sel_branch = 1'b0;
        mem_stall        = 1'b0;
        advance          = 1'b0;
        branch_taken     = 1'b0;

        if (!rst) begin
            if (state != ST_ERR) begin
                hz.dmem_req = mem_access;
                mem_stall   = mem_access & ~hz.dmem_ready;
            end

            case (state)
                ST_RUN: begin
                    if (mem_stall) begin
                        state_nxt    = ST_MEM_WAIT;
                        wait_cnt_nxt = WAIT_W'(1);
                    end else begin
                        advance = 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    if (!hz.dmem_ready) begin
                        if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
                            state_nxt = ST_ERR;
                        end else begin
                            wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                        end
                    end else begin
                        advance      = 1'b1;
                        state_nxt    = ST_RUN;
                        wait_cnt_nxt = '0;
                    end
                end
                default: state_nxt = ST_ERR;
            endcase

            // Branch beats load-use; a frozen EX keeps PCSrc until the stall releases
            if (advance) begin
                hz.pc_write     = 1'b1;
                hz.if_id_write  = 1'b1;
                hz.id_ex_write  = 1'b1;
                hz.ex_mem_write = 1'b1;
                if (hz.PCSrc) begin
                    hz.pc_sel_branch = 1'b1;
                    hz.if_id_flush   = 1'b1;
                    hz.id_ex_flush   = 1'b1;
                    branch_taken     = 1'b1;
                end else if (load_use) begin
                    hz.pc_write    = 1'b0;
                    hz.if_id_write = 1'b0;
                    hz.id_ex_flush = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hz.stall_cycles <= '0;
            hz.flush_count  <= '0;
        end else begin
            if ((state != ST_ERR) && !hz.pc_write && (hz.stall_cycles != '1))
                hz.stall_cycles <= hz.stall_cycles + CNT_BITWIDTH'(1);
            if (branch_taken && (hz.flush_count != '1))
                hz.flush_count <= hz.flush_count + CNT_BITWIDTH'(1);
        end
    end

    assign hz.err = (state == ST_ERR);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: per-cycle expected controls queued at drive time.
module tb_pipe_hazard_ctrl;
    localparam int unsigned RW = 5;
    localparam int unsigned CW = 4;

    // {pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush, id_ex_flush, pc_sel_branch, dmem_req, err}
    localparam logic [8:0] O_ADV   = 9'b1111_00_0_0_0;
    localparam logic [8:0] O_ADV_M = 9'b1111_00_0_1_0;
    localparam logic [8:0] O_FRZ_M = 9'b0000_00_0_1_0;
    localparam logic [8:0] O_LU    = 9'b0011_01_0_0_0;
    localparam logic [8:0] O_BR    = 9'b1111_11_1_0_0;
    localparam logic [8:0] O_BR_M  = 9'b1111_11_1_1_0;
    localparam logic [8:0] O_ERR   = 9'b0000_00_0_0_1;
    localparam logic [8:0] O_RST   = 9'b0000_00_0_0_0;

    typedef struct {
        string      tag;
        logic [8:0] outs;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];
    logic [8:0] outs;

    pipe_hazard_ctrl_if #(.REG_NUM_BITWIDTH(RW), .CNT_BITWIDTH(CW)) hz();

    pipe_hazard_ctrl #(.REG_NUM_BITWIDTH(RW), .CNT_BITWIDTH(CW), .MEM_TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    always #5 clk = ~clk;

    assign outs = {hz.pc_write, hz.if_id_write, hz.id_ex_write, hz.ex_mem_write,
                   hz.if_id_flush, hz.id_ex_flush, hz.pc_sel_branch, hz.dmem_req, hz.err};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        hz.id_rs1 = '0; hz.id_rs2 = '0; hz.ex_memRead = 1'b0; hz.ex_regToWrite = '0;
        hz.PCSrc = 1'b0; hz.mem_memRead = 1'b0; hz.mem_memWrite = 1'b0; hz.dmem_ready = 1'b1;
    endtask

    // One clock: queue expectation, compare at negedge, leave just after next posedge
    task automatic cyc(input string tag, input logic [8:0] exp);
        exp_t e;
        sb_q.push_back('{tag, exp});
        @(negedge clk);
        e = sb_q.pop_front();
        check(e.tag, 32'(outs), 32'(e.outs));
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input string tag, input int stall, input int flush);
        check({tag, "_stall"}, 32'(hz.stall_cycles), 32'(stall));
        check({tag, "_flush"}, 32'(hz.flush_count), 32'(flush));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
    endtask

    initial begin
        idle();
        hz.mem_memRead = 1'b1;
        hz.PCSrc       = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("reset_outs", 32'(outs), 32'(O_RST));
        check_cnt("reset", 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();

        cyc("idle", O_ADV);
        hz.ex_memRead = 1'b1; hz.ex_regToWrite = 5'd5; hz.id_rs2 = 5'd5;
        cyc("lu_rs2", O_LU);
        check_cnt("lu_rs2", 1, 0);
        idle();
        hz.ex_memRead = 1'b1; hz.ex_regToWrite = 5'd0; hz.id_rs1 = 5'd0;
        cyc("x0_excl", O_ADV);
        idle();
        hz.ex_memRead = 1'b1; hz.ex_regToWrite = 5'd7; hz.id_rs1 = 5'd7; hz.id_rs2 = 5'd3;
        cyc("lu_rs1", O_LU);
        idle();
        hz.ex_regToWrite = 5'd7; hz.id_rs1 = 5'd7;
        cyc("no_load", O_ADV);
        check_cnt("after_lu", 2, 0);

        idle();
        hz.PCSrc = 1'b1;
        cyc("branch", O_BR);
        check_cnt("branch", 2, 1);

        idle();
        hz.mem_memRead = 1'b1; hz.dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc("mem_wait", O_FRZ_M);
        hz.dmem_ready = 1'b1;
        cyc("mem_release", O_ADV_M);
        idle();
        cyc("mem_after", O_ADV);
        check_cnt("mem_wait", 5, 1);

        // Branch, load-use and memory stall together
        do_reset();
        hz.PCSrc = 1'b1; hz.ex_memRead = 1'b1; hz.ex_regToWrite = 5'd9; hz.id_rs1 = 5'd9;
        hz.mem_memWrite = 1'b1; hz.dmem_ready = 1'b0;
        cyc("simul_frz0", O_FRZ_M);
        cyc("simul_frz1", O_FRZ_M);
        hz.dmem_ready = 1'b1;
        cyc("simul_branch", O_BR_M);
        idle();
        cyc("simul_after", O_ADV);
        check_cnt("simul", 2, 1);

        // Timeout into ERR, then asynchronous clear
        do_reset();
        hz.mem_memWrite = 1'b1; hz.dmem_ready = 1'b0;
        for (int i = 0; i < 5; i++) cyc("to_wait", O_FRZ_M);
        cyc("to_err0", O_ERR);
        idle();
        hz.PCSrc = 1'b1; hz.mem_memRead = 1'b1;
        cyc("to_err1", O_ERR);
        cyc("to_err2", O_ERR);
        check_cnt("timeout", 5, 0);
        rst = 1'b1;
        #2;
        check("err_async_rst", 32'(outs), 32'(O_RST));
        check_cnt("err_async_rst", 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        cyc("err_resume", O_ADV);

        // Asynchronous reset in the middle of a memory wait
        hz.mem_memRead = 1'b1; hz.dmem_ready = 1'b0;
        cyc("mw_frz0", O_FRZ_M);
        cyc("mw_frz1", O_FRZ_M);
        rst = 1'b1;
        #2;
        check("mw_async_rst", 32'(outs), 32'(O_RST));
        check_cnt("mw_async_rst", 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        hz.dmem_ready = 1'b1;
        cyc("mw_resume", O_ADV_M);

        // Counter saturation
        do_reset();
        hz.ex_memRead = 1'b1; hz.ex_regToWrite = 5'd4; hz.id_rs2 = 5'd4;
        for (int i = 0; i < 20; i++) cyc("sat_lu", O_LU);
        check_cnt("sat_stall", 15, 0);
        idle();
        hz.PCSrc = 1'b1;
        for (int i = 0; i < 18; i++) cyc("sat_br", O_BR);
        check_cnt("sat_flush", 15, 15);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_NUM_BITWIDTH, default 5, register-index width.
REQ-002 SHALL have parameter CNT_BITWIDTH, default 32, width of the performance counters.
REQ-003 SHALL have parameter MEM_TIMEOUT, default 16, the maximum number of data-memory wait cycles before an error is declared (legal range 2..255).
REQ-004 SHALL have one clock and an asynchronous, active-high reset, named as in the rest of the codebase.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- id_rs1, id_rs2  in  REG_NUM_BITWIDTH  source registers of the instruction in ID
- ex_memRead  in  1  instruction in EX is a load
- ex_regToWrite  in  REG_NUM_BITWIDTH  destination register of EX
- PCSrc  in  1  branch taken, resolved in EX
- mem_memRead, mem_memWrite  in  1  instruction in MEM accesses data memory
- dmem_ready  in  1  data memory completes this cycle
- pc_write, if_id_write, id_ex_write, ex_mem_write  out  1  stage-register enables (1 = advance)
- if_id_flush, id_ex_flush  out  1  load a bubble into the stage register
- pc_sel_branch  out  1  PC takes the branch target
- dmem_req  out  1  data-memory request
- err  out  1  sticky memory-timeout error
- stall_cycles, flush_count  out  CNT_BITWIDTH  performance counters

Function
REQ-005 SHALL compute load-use hazard LU = ex_memRead & (ex_regToWrite != 0) & (ex_regToWrite == id_rs1 | ex_regToWrite == id_rs2).
REQ-006 SHALL compute MA = mem_memRead | mem_memWrite.
REQ-007 SHALL drive dmem_req = MA in states RUN and MEM_WAIT, and 0 in state ERR.
REQ-008 SHALL compute memory stall MS = dmem_req & ~dmem_ready.
REQ-009 SHALL implement states RUN, MEM_WAIT and ERR; all outputs other than the counters and err are combinational from the state and the current inputs.
REQ-010 In RUN with MS, SHALL deassert all four write enables, assert no flush, hold pc_sel_branch at 0, and go to MEM_WAIT.
REQ-011 In RUN without MS and with PCSrc, SHALL assert pc_sel_branch, if_id_flush and id_ex_flush, keep all enables at 1, and increment flush_count. Priority order: MS over PCSrc over LU.
REQ-012 In RUN without MS or PCSrc and with LU, SHALL deassert pc_write and if_id_write, assert id_ex_flush, and keep ex_mem_write at 1 (a single-cycle bubble).
REQ-013 In RUN otherwise, SHALL drive all enables to 1 and all flushes to 0.
REQ-014 In MEM_WAIT, the wait counter SHALL start at 1 on entry; each cycle with ~dmem_ready, SHALL hold all enables at 0 and increment the wait counter.
REQ-015 In MEM_WAIT, when dmem_ready=1, SHALL evaluate RUN rules REQ-011..013 in the same cycle, return to RUN, and clear the wait counter.
REQ-016 In MEM_WAIT, a cycle with ~dmem_ready while the wait counter equals MEM_TIMEOUT SHALL cause a transition to ERR.
REQ-017 ERR SHALL be absorbing until reset: all enables 0, all flushes 0, dmem_req 0, err 1.
REQ-018 stall_cycles SHALL increment on every cycle in RUN or MEM_WAIT with pc_write=0.
REQ-019 Both counters SHALL saturate at all-ones and never wrap.
REQ-020 A PCSrc asserted during a memory stall SHALL NOT be acted on until the stall releases, because EX is frozen and PCSrc persists.

Reset
REQ-021 While rst=1, SHALL force state RUN, wait counter 0, err 0, stall_cycles 0, flush_count 0.
REQ-022 While rst=1, SHALL drive all enables, flushes, pc_sel_branch and dmem_req to 0.
REQ-023 On reset deassertion, SHALL resume in RUN on the next rising clock edge.
REQ-024 Reset asserted mid-MEM_WAIT or in ERR SHALL take effect immediately and asynchronously.

Verification
REQ-025 Load-use: ex_memRead=1, ex_regToWrite=5, id_rs2=5, other inputs idle -> one cycle with pc_write=0, if_id_write=0, id_ex_flush=1; stall_cycles=1.
REQ-026 x0 exclusion: ex_memRead=1, ex_regToWrite=0, id_rs1=0 -> no stall; all enables 1.
REQ-027 Memory wait: mem_memRead=1, dmem_ready low for 3 cycles then high -> all enables 0 for 3 cycles, then advance; state back to RUN; stall_cycles=3.
REQ-028 Simultaneous events: PCSrc=1 with MS and LU -> freeze only; after dmem_ready, one cycle of pc_sel_branch=1 with both flushes; flush_count=1.
REQ-029 Timeout with MEM_TIMEOUT=4: mem_memWrite=1, dmem_ready held 0 -> ERR after the 4th wait cycle; err=1 and dmem_req=0 permanently; asynchronous rst clears everything.
REQ-030 Saturation: preload or force stall_cycles to all-ones, then stall -> value stays all-ones.
